fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction port (imem_*) of the dual-port memory.
- Owns the PC and issues one word read at a time.
- Buffers returned instructions, tagged with their PC, in a small flushable queue for the decode stage.
- Handles control-flow redirects, including discarding a response already in flight.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 78 +++++++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, queue entry, PC helpers.
// No logic of its own; imported by fetch_queue and fetch_unit.
// Entry layout keeps the PC alongside the instruction so decode never recomputes it.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Flushable instruction queue of ifq_entry_t between fetch and decode.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pop is ignored when empty; flush wins over push and pop; push is dropped when full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  ifq_entry_t                   push_dat,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         head_vld,
    output ifq_entry_t                   head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    ifq_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign head_vld = (count != '0);
    assign do_push  = push & ~flush & ~full;
    assign do_pop   = pop & ~flush & head_vld;

    // The fetch FSM uses the post-update occupancy to decide whether it has credit.
    always_comb begin
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(do_push) - CW'(do_pop);
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single-word reads, queues {pc, instr} for decode.
// Latency: reset release to first head is 3 cycles with a 1-cycle memory; one instruction per 2 cycles.
// Backpressure: stops requesting when the queue would be full; resumes as soon as a slot frees.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifq_valid,
    output logic [31:0] ifq_pc,
    output logic [31:0] ifq_instr,
    input  logic        ifq_ready
);

    localparam int          CW          = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'd3;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   pc;
    logic          push;
    logic          pop;
    logic          credit;
    logic [CW-1:0] q_count_nxt;
    ifq_entry_t    push_dat;
    ifq_entry_t    head;

    // Masking the read in the response cycle keeps at most one request outstanding.
    assign imem_read    = (state == FETCH) & ~imem_resp;
    assign imem_address = pc;

    assign push     = (state == FETCH) & imem_resp & ~redirect_valid;
    assign pop      = ifq_valid & ifq_ready & ~redirect_valid;
    assign credit   = (q_count_nxt < CW'(DEPTH));
    assign push_dat = '{pc: pc, instr: imem_rdata};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (redirect_valid || credit) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    // A request committed this cycle must be waited out and discarded.
                    state_nxt = imem_resp ? FETCH : DRAIN;
                end else if (imem_resp && !credit) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (imem_resp) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC_AL;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc <= align_pc(redirect_pc);
            end else if (push) begin
                pc <= pc + 32'(INSTR_BYTES);
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_dat   (push_dat),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_vld   (ifq_valid),
        .head_dat   (head),
        .count_next (q_count_nxt)
    );

    assign ifq_pc    = head.pc;
    assign ifq_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue/flag reference model checked every cycle plus literal checkpoints.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifq_valid;
    logic [31:0] ifq_pc;
    logic [31:0] ifq_instr;
    logic        ifq_ready;

    int n_vec = 0;
    int n_bad = 0;
    int mem_lat = 1;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0060),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifq_valid      (ifq_valid),
        .ifq_pc         (ifq_pc),
        .ifq_instr      (ifq_instr),
        .ifq_ready      (ifq_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h60) return 32'h0000_0013;
        if (a == 32'h64) return 32'h0010_0093;
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory: every cycle with imem_read=1 at the edge is a request, answered mem_lat cycles later.
    initial begin : responder
        logic [31:0] pq_addr [$];
        int          pq_due  [$];
        int          cyc;
        cyc        = 0;
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pq_due.size() > 0 && pq_due[0] == cyc) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(pq_addr[0]);
                void'(pq_addr.pop_front());
                void'(pq_due.pop_front());
            end else begin
                imem_resp  = 1'b0;
                imem_rdata = 32'h0;
            end
            @(negedge clk);
            if (imem_read) begin
                pq_addr.push_back(imem_address);
                pq_due.push_back(cyc + mem_lat);
            end
        end
    end

    // Reference model: pc, a queue of entries, and whether the in-flight request is kept or discarded.
    initial begin : compare
        ifq_entry_t  q [$];
        logic [31:0] m_pc;
        bit          m_ok;
        bit          m_en;
        bit          m_live;
        bit          m_stale;
        bit          e_read;
        bit          e_vld;
        bit          inflight;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        m_ok = 0; m_en = 0; m_live = 0; m_stale = 0; m_pc = 32'h0;
        forever begin
            @(negedge clk);
            e_read = m_en && !m_stale && !imem_resp;
            e_vld  = (q.size() > 0);
            e_pc   = e_vld ? q[0].pc : 32'h0;
            e_ins  = e_vld ? q[0].instr : 32'h0;
            if (m_ok) begin
                n_vec++;
                if (imem_read !== e_read || imem_address !== m_pc || ifq_valid !== e_vld ||
                    ifq_pc !== e_pc || ifq_instr !== e_ins) begin
                    n_bad++;
                    $display("FAIL model t=%0t read %b want %b addr %h want %h vld %b want %b pc %h want %h instr %h want %h",
                             $time, imem_read, e_read, imem_address, m_pc, ifq_valid, e_vld,
                             ifq_pc, e_pc, ifq_instr, e_ins);
                end
                n_vec++;
                if (imem_read && imem_resp) begin
                    n_bad++;
                    $display("FAIL read_in_resp_cycle t=%0t read %b want 0", $time, imem_read);
                end
            end
            if (!rst_n) begin
                q.delete();
                m_pc = 32'h60; m_en = 0; m_live = 0; m_stale = 0; m_ok = 1;
            end else if (m_ok) begin
                inflight = ((m_live || m_stale) && !imem_resp) || e_read;
                if (redirect_valid) begin
                    q.delete();
                    m_pc    = {redirect_pc[31:2], 2'b00};
                    m_stale = inflight;
                    m_live  = 0;
                end else begin
                    if (q.size() > 0 && ifq_ready) void'(q.pop_front());
                    if (imem_resp && m_live) begin
                        q.push_back('{pc: m_pc, instr: imem_rdata});
                        m_pc = m_pc + 32'd4;
                    end
                    m_stale = m_stale && !imem_resp;
                    m_live  = (m_live && !imem_resp) || e_read;
                end
                m_en = (q.size() < DEPTH);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic reset_to_cycle0(input logic rdy);
        rst_n = 1'b0;
        ifq_ready = rdy;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin : stim
        logic [47:0] rpat;
        rst_n = 1'b0; ifq_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset stream: read at 0x60 in cycle 1, heads in cycles 3 and 5.
        reset_to_cycle0(1'b1);
        chk("rst_read", 32'(imem_read), 32'h0);
        chk("rst_addr", imem_address, 32'h60);
        chk("rst_vld", 32'(ifq_valid), 32'h0);
        chk("rst_pc", ifq_pc, 32'h0);
        chk("rst_instr", ifq_instr, 32'h0);
        tick(); #1;
        chk("c1_read", 32'(imem_read), 32'h1);
        chk("c1_addr", imem_address, 32'h60);
        tick(); #1;
        chk("c2_read_masked", 32'(imem_read), 32'h0);
        tick(); #1;
        chk("c3_vld", 32'(ifq_valid), 32'h1);
        chk("c3_pc", ifq_pc, 32'h60);
        chk("c3_instr", ifq_instr, 32'h0000_0013);
        chk("c3_addr", imem_address, 32'h64);
        tick(); tick(); #1;
        chk("c5_pc", ifq_pc, 32'h64);
        chk("c5_instr", ifq_instr, 32'h0010_0093);

        // Backpressure: four pushes fill the queue, one pop restarts fetching at 0x70.
        reset_to_cycle0(1'b0);
        repeat (9) tick();
        #1;
        chk("bp_read_idle", 32'(imem_read), 32'h0);
        chk("bp_count", 32'(dut.u_queue.count), 32'd4);
        chk("bp_head", ifq_pc, 32'h60);
        tick();
        ifq_ready = 1'b1;
        #1;
        chk("bp_still_idle", 32'(imem_read), 32'h0);
        tick();
        ifq_ready = 1'b0;
        #1;
        chk("bp_resume_read", 32'(imem_read), 32'h1);
        chk("bp_resume_addr", imem_address, 32'h70);
        chk("bp_head_after_pop", ifq_pc, 32'h64);

        // Redirect in flight: cycle 1 request is discarded via DRAIN.
        reset_to_cycle0(1'b1);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("drain_read", 32'(imem_read), 32'h0);
        chk("drain_vld", 32'(ifq_valid), 32'h0);
        tick(); #1;
        chk("redir_read", 32'(imem_read), 32'h1);
        chk("redir_addr", imem_address, 32'h200);
        tick();
        ifq_ready = 1'b0;
        tick(); #1;
        chk("redir_head_pc", ifq_pc, 32'h200);
        chk("redir_head_instr", ifq_instr, 32'hDEAD_0200);

        // Redirect coinciding with a response and a pop: data dropped, pop ignored.
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h203; ifq_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rr_read", 32'(imem_read), 32'h1);
        chk("rr_addr", imem_address, 32'h200);
        chk("rr_count", 32'(dut.u_queue.count), 32'd0);
        chk("rr_vld", 32'(ifq_valid), 32'h0);

        // Reset during DRAIN with a 2-cycle response arriving after reset.
        tick(); tick();
        mem_lat = 2;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        mem_lat = 1;
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rd_drain_read", 32'(imem_read), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rd_stale_resp", 32'(imem_resp), 32'h1);
        chk("rd_read", 32'(imem_read), 32'h0);
        chk("rd_addr", imem_address, 32'h60);
        chk("rd_count", 32'(dut.u_queue.count), 32'd0);
        chk("rd_vld", 32'(ifq_valid), 32'h0);
        tick(); #1;
        chk("rd_restart_addr", imem_address, 32'h60);
        chk("rd_restart_read", 32'(imem_read), 32'h1);
        chk("rd_no_stale_push", 32'(ifq_valid), 32'h0);
        tick(); tick(); #1;
        chk("rd_head_pc", ifq_pc, 32'h60);
        chk("rd_head_instr", ifq_instr, 32'h0000_0013);

        // Mixed consumer pattern with two redirects, checked by the model only.
        rpat = 48'hF0C3_A5E1_0FF3;
        for (int i = 0; i < 48; i++) begin
            tick();
            ifq_ready      = rpat[i];
            redirect_valid = (i == 17) || (i == 30);
            redirect_pc    = (i == 17) ? 32'h0000_1000 : 32'h0000_0ABE;
        end
        tick();
        redirect_valid = 1'b0;
        ifq_ready = 1'b1;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
